reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Register-file write-back end of the datapath. It is the producer of ReadData1/ReadData2, which the ALU operand-B source mux consumes, and the consumer of ALU and memory results.
- Contains:
  - the ALU-output holding register (ALUoutDR);
  - the memory-data holding register (DBDR);
  - the write-data and destination selection;
  - a 32x32 register file with two read ports and one write port.
- Sits between the ALU/data-memory outputs and the decode-stage operand reads of the multicycle CPU.

Parameters:
- WIDTH, 32, data width of registers and buses.
- NREG, 32, number of architectural registers (address width = log2(NREG) = 5).
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- ReadReg1  input  5  rs address for port 1.
- ReadReg2  input  5  rt address for port 2.
- ReadData1  output  WIDTH  combinational read of ReadReg1.
- ReadData2  output  WIDTH  combinational read of ReadReg2.
- rt  input  5  instruction rt field.
- rd  input  5  instruction rd field.
- RegDst  input  2  destination select: 00 rt, 01 rd, 10 $31, 11 reserved (no write).
- ALUResult  input  WIDTH  ALU output, captured into ALUoutDR.
- MemData  input  WIDTH  data-memory output, captured into DBDR.
- PC4  input  WIDTH  PC+4, used for jal link.
- ALUoutLd  input  1  load enable for ALUoutDR.
- DBDRLd  input  1  load enable for DBDR.
- WrRegDSrc  input  2  write-data select: 00 ALUoutDR, 01 DBDR, 10 PC4, 11 reserved (no write).
- RegWre  input  1  register-file write enable.
- WriteReg  output  5  resolved destination address (for debug/display).
- WriteData  output  WIDTH  resolved write data (for debug/display).

Behaviour:
- Reset is asserted asynchronously:
  - all NREG registers, ALUoutDR and DBDR become 0 immediately;
  - ReadData1, ReadData2 and WriteData therefore read 0;
  - WriteReg resolves combinationally from inputs.
- ALUoutDR loads ALUResult on a rising CLK when ALUoutLd=1; otherwise it holds. DBDR loads MemData likewise under DBDRLd. Latency from input to holding register is 1 cycle.
- WriteReg and WriteData are combinational from RegDst, WrRegDSrc, the holding registers and PC4.
- Register write:
  - occurs on the rising CLK when RegWre=1, WriteReg!=0, RegDst!=11 and WrRegDSrc!=11;
  - otherwise the register file is unchanged.
  - A written value is visible on the read ports from the following cycle (BYPASS=0), or in the same cycle (BYPASS=1, see below).
- $0: a read of address 0 always returns 0. A write to address 0 is silently dropped; no storage exists for $0.
- Bypass (BYPASS=1): if a write is qualified and ReadRegN==WriteReg!=0, then ReadDataN=WriteData combinationally. Both ports may bypass at once.
- Simultaneous holding-register load and write-back in the same cycle: the write uses the pre-edge ALUoutDR/DBDR value; the new value lands in the holding register.
- Reset asserted mid-write (Reset high at the CLK edge): reset wins, and no write takes effect.
- Reset deasserted: the first possible write is on the next rising CLK.
- Reserved selects (11) never corrupt state; WriteData reads 0 for WrRegDSrc=11.
- There is no state machine. Sequencing is owned by the control unit, and this block is purely enable-driven.

Decomposition:
- Shared package: constants for the RegDst encodings (RD_RT, RD_RD, RD_RA), the WrRegDSrc encodings (WD_ALU, WD_MEM, WD_PC4), RA_ADDR=31, and WIDTH.
- One natural sub-module: reg_file (storage, two read ports, one write port, $0 handling, optional bypass).
- The holding registers and the selection logic stay in reg_writeback.

Test Plan:
- Reset to zero: pulse Reset high mid-cycle with the register file preloaded → ReadData1/2=0 for every address, before the next CLK edge.
- ALU write-back:
  - Cycle 1: ALUResult=0x0000_1234, ALUoutLd=1.
  - Cycle 2: RegDst=01, rd=8, WrRegDSrc=00, RegWre=1.
  - Cycle 3: ReadReg1=8 → ReadData1=0x0000_1234.
- Load write-back: DBDRLd=1 with MemData=0xDEAD_BEEF, then RegDst=00, rt=9, WrRegDSrc=01, RegWre=1 → $9=0xDEAD_BEEF. $8 is unchanged.
- jal link: PC4=0x0040_0008, RegDst=10, WrRegDSrc=10, RegWre=1 → WriteReg=31 and $31=0x0040_0008.
- $0 protection: write 0xFFFF_FFFF to rd=0 → ReadData1 with ReadReg1=0 stays 0.
- Bypass and reserved/reset edges:
  - BYPASS=1, a write of 0x55 to $5 with ReadReg2=5 in the same cycle → ReadData2=0x55 before the edge.
  - RegDst=11 with RegWre=1 → no register changes.
  - Reset high coincident with a write edge → target register reads 0.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared constants for the register write-back slice.
//   WIDTH / NREG / AW  : data width, register count, register address width
//   RD_*               : RegDst encodings (destination select)
//   WD_*               : WrRegDSrc encodings (write-data select)
//   RA_ADDR            : link register used by jal
package reg_writeback_pkg;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int AW    = 5;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_RA  = 2'b10;
  localparam logic [1:0] RD_RSV = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  localparam logic [1:0] WD_RSV = 2'b11;

  localparam logic [AW-1:0] RA_ADDR = 5'd31;

endpackage

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: bundles the operand-read, result-capture and write-back
// control signals of the write-back block.
//   master : control unit / datapath side (drives addresses, data, enables)
//   slave  : reg_writeback side (returns read data and resolved write-back)
interface reg_writeback_if #(
  parameter int WIDTH = reg_writeback_pkg::WIDTH
) ();
  import reg_writeback_pkg::*;

  logic [AW-1:0]    ReadReg1;
  logic [AW-1:0]    ReadReg2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [AW-1:0]    rt;
  logic [AW-1:0]    rd;
  logic [1:0]       RegDst;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] MemData;
  logic [WIDTH-1:0] PC4;
  logic             ALUoutLd;
  logic             DBDRLd;
  logic [1:0]       WrRegDSrc;
  logic             RegWre;
  logic [AW-1:0]    WriteReg;
  logic [WIDTH-1:0] WriteData;

  modport master (
    output ReadReg1, ReadReg2, rt, rd, RegDst, ALUResult, MemData, PC4,
           ALUoutLd, DBDRLd, WrRegDSrc, RegWre,
    input  ReadData1, ReadData2, WriteReg, WriteData
  );

  modport slave (
    input  ReadReg1, ReadReg2, rt, rd, RegDst, ALUResult, MemData, PC4,
           ALUoutLd, DBDRLd, WrRegDSrc, RegWre,
    output ReadData1, ReadData2, WriteReg, WriteData
  );

endinterface

// File: rtl/reg_writeback_reg_file.sv
// reg_file: NREG x WIDTH register file, two combinational read ports and one
// synchronous write port. Address 0 has no storage and always reads 0; writes
// to it are dropped. With BYPASS!=0 a write presented this cycle is forwarded
// to any read port addressing the same register.
//   clk, rst         : clock, asynchronous active-high clear
//   we, waddr, wdata : write port (we is already fully qualified by the caller)
//   raddr1/rdata1    : read port 1
//   raddr2/rdata2    : read port 2
module reg_file #(
  parameter int WIDTH  = reg_writeback_pkg::WIDTH,
  parameter int NREG   = reg_writeback_pkg::NREG,
  parameter int BYPASS = 1,
  parameter int AW     = reg_writeback_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  // Entries 1..NREG-1 only; $0 is hard-wired.
  logic [WIDTH-1:0] regs_r [1:NREG-1];

  // Register storage: cleared by reset, written on the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we && (waddr != {AW{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read port 1: $0 forced to zero, then optional same-cycle forwarding
  always_comb begin
    rdata1 = {WIDTH{1'b0}};
    if (raddr1 == {AW{1'b0}}) begin
      rdata1 = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_r[raddr1];
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rdata2 = {WIDTH{1'b0}};
    if (raddr2 == {AW{1'b0}}) begin
      rdata2 = {WIDTH{1'b0}};
    end else if ((BYPASS != 0) && we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: write-back end of the multicycle datapath.
//   CLK, Reset : clock, asynchronous active-high clear of all state
//   bus        : reg_writeback_if.slave
//     ReadReg1/2 -> ReadData1/2   operand reads (combinational)
//     ALUResult/ALUoutLd          captured into ALUoutDR
//     MemData/DBDRLd              captured into DBDR
//     rt, rd, RegDst              destination select -> WriteReg
//     WrRegDSrc, PC4              write-data select  -> WriteData
//     RegWre                      register-file write enable
// A write is qualified only when RegWre=1, the destination is not $0 and
// neither select uses its reserved encoding. Because the holding registers
// update on the same edge as the register file, a write-back always uses the
// pre-edge ALUoutDR/DBDR contents.
module reg_writeback #(
  parameter int WIDTH  = reg_writeback_pkg::WIDTH,
  parameter int NREG   = reg_writeback_pkg::NREG,
  parameter int BYPASS = 1
) (
  input  logic           CLK,
  input  logic           Reset,
  reg_writeback_if.slave bus
);
  import reg_writeback_pkg::*;

  logic [WIDTH-1:0] alu_out_dr_r;
  logic [WIDTH-1:0] dbdr_r;
  logic [AW-1:0]    write_reg_s;
  logic [WIDTH-1:0] write_data_s;
  logic             write_en_s;

  // Result holding registers (ALUoutDR, DBDR) with independent load enables
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      alu_out_dr_r <= {WIDTH{1'b0}};
      dbdr_r       <= {WIDTH{1'b0}};
    end else begin
      if (bus.ALUoutLd) begin
        alu_out_dr_r <= bus.ALUResult;
      end
      if (bus.DBDRLd) begin
        dbdr_r <= bus.MemData;
      end
    end
  end

  // Destination register select
  always_comb begin
    write_reg_s = {AW{1'b0}};
    case (bus.RegDst)
      RD_RT:   write_reg_s = bus.rt;
      RD_RD:   write_reg_s = bus.rd;
      RD_RA:   write_reg_s = RA_ADDR;
      default: write_reg_s = {AW{1'b0}};
    endcase
  end

  // Write-data select; held at zero while Reset is asserted so that the
  // debug output and any forwarded read also show the cleared state
  always_comb begin
    write_data_s = {WIDTH{1'b0}};
    if (Reset) begin
      write_data_s = {WIDTH{1'b0}};
    end else begin
      case (bus.WrRegDSrc)
        WD_ALU:  write_data_s = alu_out_dr_r;
        WD_MEM:  write_data_s = dbdr_r;
        WD_PC4:  write_data_s = bus.PC4;
        default: write_data_s = {WIDTH{1'b0}};
      endcase
    end
  end

  // Write qualification: reserved selects and $0 never write, reset wins
  always_comb begin
    write_en_s = 1'b0;
    if (!Reset && bus.RegWre && (write_reg_s != {AW{1'b0}}) &&
        (bus.RegDst != RD_RSV) && (bus.WrRegDSrc != WD_RSV)) begin
      write_en_s = 1'b1;
    end else begin
      write_en_s = 1'b0;
    end
  end

  reg_file #(
    .WIDTH  (WIDTH),
    .NREG   (NREG),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_reg_file (
    .clk    (CLK),
    .rst    (Reset),
    .we     (write_en_s),
    .waddr  (write_reg_s),
    .wdata  (write_data_s),
    .raddr1 (bus.ReadReg1),
    .raddr2 (bus.ReadReg2),
    .rdata1 (bus.ReadData1),
    .rdata2 (bus.ReadData2)
  );

  assign bus.WriteReg  = write_reg_s;
  assign bus.WriteData = write_data_s;

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scenarios plus randomized traffic for
// reg_writeback, compared every cycle against an array-based model.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic CLK = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  reg_writeback_if #(.WIDTH(WIDTH)) bus ();

  reg_writeback #(.WIDTH(WIDTH), .NREG(NREG), .BYPASS(1)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #50 CLK = ~CLK;

  // Reference model: architectural registers and the two holding registers
  logic [31:0] m_regs [32];
  logic [31:0] m_alu;
  logic [31:0] m_mem;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_alu = 32'd0;
    m_mem = 32'd0;
  endtask

  function automatic logic [4:0] exp_dst();
    if (bus.RegDst == 2'd0) return bus.rt;
    else if (bus.RegDst == 2'd1) return bus.rd;
    else if (bus.RegDst == 2'd2) return 5'd31;
    else return 5'd0;
  endfunction

  function automatic logic [31:0] exp_data();
    if (Reset) return 32'd0;
    if (bus.WrRegDSrc == 2'd0) return m_alu;
    if (bus.WrRegDSrc == 2'd1) return m_mem;
    if (bus.WrRegDSrc == 2'd2) return bus.PC4;
    return 32'd0;
  endfunction

  function automatic logic exp_we();
    return !Reset && bus.RegWre && (bus.RegDst != 2'd3) &&
           (bus.WrRegDSrc != 2'd3) && (exp_dst() != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_we() && (a == exp_dst())) return exp_data();
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rd1", bus.ReadData1, exp_read(bus.ReadReg1));
    check("rd2", bus.ReadData2, exp_read(bus.ReadReg2));
    check("wdata", bus.WriteData, exp_data());
    if (bus.RegDst != 2'd3) check("wreg", {27'd0, bus.WriteReg}, {27'd0, exp_dst()});
  endtask

  // Compare, then advance model and DUT across one rising edge
  task automatic step();
    logic        we;
    logic [4:0]  d;
    logic [31:0] wd, na, nm;
    compare_all();
    we = exp_we();
    d  = exp_dst();
    wd = exp_data();
    na = bus.ALUoutLd ? bus.ALUResult : m_alu;
    nm = bus.DBDRLd ? bus.MemData : m_mem;
    @(posedge CLK);
    if (Reset) begin
      model_clear();
    end else begin
      if (we) m_regs[d] = wd;
      m_alu = na;
      m_mem = nm;
    end
    #1;
  endtask

  task automatic settle();
    #40;
  endtask

  task automatic idle();
    bus.ReadReg1 = 5'd0;  bus.ReadReg2 = 5'd0;
    bus.rt = 5'd0;        bus.rd = 5'd0;
    bus.RegDst = 2'd0;    bus.WrRegDSrc = 2'd0;
    bus.ALUResult = 32'd0; bus.MemData = 32'd0; bus.PC4 = 32'd0;
    bus.ALUoutLd = 1'b0;  bus.DBDRLd = 1'b0;  bus.RegWre = 1'b0;
  endtask

  initial begin
    model_clear();
    Reset = 1'b1;
    idle();
    @(posedge CLK); #1;

    // Reset state
    bus.ReadReg1 = 5'd3; bus.ReadReg2 = 5'd17;
    settle();
    check("reset_rd1", bus.ReadData1, 32'd0);
    step();
    Reset = 1'b0;

    // ALU write-back
    idle(); bus.ALUResult = 32'h0000_1234; bus.ALUoutLd = 1'b1;
    settle(); step();
    idle(); bus.RegDst = 2'b01; bus.rd = 5'd8; bus.WrRegDSrc = 2'b00; bus.RegWre = 1'b1;
    settle(); step();
    idle(); bus.ReadReg1 = 5'd8;
    settle();
    check("alu_wb", bus.ReadData1, 32'h0000_1234);
    step();

    // Load write-back
    idle(); bus.MemData = 32'hDEAD_BEEF; bus.DBDRLd = 1'b1;
    settle(); step();
    idle(); bus.RegDst = 2'b00; bus.rt = 5'd9; bus.WrRegDSrc = 2'b01; bus.RegWre = 1'b1;
    settle(); step();
    idle(); bus.ReadReg1 = 5'd9; bus.ReadReg2 = 5'd8;
    settle();
    check("load_wb", bus.ReadData1, 32'hDEAD_BEEF);
    check("load_keep8", bus.ReadData2, 32'h0000_1234);
    step();

    // jal link
    idle(); bus.PC4 = 32'h0040_0008; bus.RegDst = 2'b10; bus.WrRegDSrc = 2'b10; bus.RegWre = 1'b1;
    settle();
    check("jal_wreg", {27'd0, bus.WriteReg}, 32'd31);
    step();
    idle(); bus.ReadReg1 = 5'd31;
    settle();
    check("jal_r31", bus.ReadData1, 32'h0040_0008);
    step();

    // $0 protection
    idle(); bus.ALUResult = 32'hFFFF_FFFF; bus.ALUoutLd = 1'b1;
    settle(); step();
    idle(); bus.RegDst = 2'b01; bus.rd = 5'd0; bus.WrRegDSrc = 2'b00; bus.RegWre = 1'b1;
    settle(); step();
    idle();
    settle();
    check("r0_zero", bus.ReadData1, 32'd0);
    step();

    // Same-cycle bypass
    idle(); bus.ALUResult = 32'h0000_0055; bus.ALUoutLd = 1'b1;
    settle(); step();
    idle(); bus.RegDst = 2'b01; bus.rd = 5'd5; bus.WrRegDSrc = 2'b00; bus.RegWre = 1'b1;
    bus.ReadReg2 = 5'd5;
    settle();
    check("bypass_rd2", bus.ReadData2, 32'h0000_0055);
    step();

    // Reserved selects leave state alone
    idle(); bus.ALUResult = 32'h0000_AAAA; bus.ALUoutLd = 1'b1;
    settle(); step();
    idle(); bus.RegDst = 2'b11; bus.rd = 5'd5; bus.rt = 5'd5; bus.RegWre = 1'b1;
    settle(); step();
    idle(); bus.RegDst = 2'b01; bus.rd = 5'd5; bus.WrRegDSrc = 2'b11; bus.RegWre = 1'b1;
    settle();
    check("rsv_wdata", bus.WriteData, 32'd0);
    step();
    idle(); bus.ReadReg1 = 5'd5;
    settle();
    check("rsv_keep5", bus.ReadData1, 32'h0000_0055);
    step();

    // Reset coincident with a write edge
    idle(); bus.ALUResult = 32'h0000_0077; bus.ALUoutLd = 1'b1;
    settle(); step();
    idle(); bus.RegDst = 2'b01; bus.rd = 5'd12; bus.WrRegDSrc = 2'b00; bus.RegWre = 1'b1;
    settle(); #5;
    Reset = 1'b1; model_clear(); #1;
    step();
    Reset = 1'b0;
    idle(); bus.ReadReg1 = 5'd12;
    settle();
    check("rst_edge_r12", bus.ReadData1, 32'd0);
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.rt        = 5'($urandom_range(0, 31));
      bus.rd        = 5'($urandom_range(0, 31));
      bus.RegDst    = 2'($urandom_range(0, 3));
      bus.WrRegDSrc = 2'($urandom_range(0, 3));
      bus.RegWre    = 1'($urandom_range(0, 1));
      bus.ALUoutLd  = 1'($urandom_range(0, 1));
      bus.DBDRLd    = 1'($urandom_range(0, 1));
      bus.ALUResult = $urandom;
      bus.MemData   = $urandom;
      bus.PC4       = $urandom;
      bus.ReadReg1  = ($urandom_range(0, 3) == 0) ? bus.rd : 5'($urandom_range(0, 31));
      bus.ReadReg2  = ($urandom_range(0, 3) == 0) ? bus.rt : 5'($urandom_range(0, 31));
      settle();
      step();
    end

    // Mid-cycle reset with a populated register file
    idle();
    Reset = 1'b1; model_clear(); #1;
    for (int i = 0; i < 32; i++) begin
      bus.ReadReg1 = 5'(i);
      bus.ReadReg2 = 5'(31 - i);
      #1;
      check("midrst_rd1", bus.ReadData1, exp_read(bus.ReadReg1));
      check("midrst_rd2", bus.ReadData2, 32'd0);
    end
    step();
    Reset = 1'b0;
    settle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
